// File: rtl/s_div_share_arbiter_if.sv
// PE-side request/response bus of the shared divider arbiter.
// The PE array is the master; the arbiter is the slave.
interface s_div_share_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int N_BITS = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*N_BITS-1:0] req_a;
  logic [N_REQ*N_BITS-1:0] req_b;
  logic [N_REQ-1:0]        req_rem;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ*N_BITS-1:0] rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_rem,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_rem,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/s_div_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined divider among N_REQ PEs.
// A tag pipe matched to the divider depth routes each result back to its issuer.
module s_div_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_BITS  = 32,
  parameter int DIV_LAT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  mage_done_i,
  input  logic                  pea_ready_i,
  s_div_share_arbiter_if.slave  pe,
  output logic                  div_en_o,
  output logic                  div_valid_o,
  output logic [N_BITS-1:0]     div_a_o,
  output logic [N_BITS-1:0]     div_b_o,
  input  logic [N_BITS-1:0]     div_q_i,
  input  logic [N_BITS-1:0]     div_r_i,
  output logic                  busy_o
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LAST = DIV_LAT - 1;
  localparam logic [ID_W-1:0] ID_MAX = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]   N_REQ_W = (ID_W + 1)'(N_REQ);

  logic                  adv;
  logic [ID_W-1:0]       ptr;
  logic                  grant_valid;
  logic [ID_W-1:0]       grant_idx;
  logic [N_REQ-1:0]      grant_vec;
  logic                  grant_rem;
  logic                  grant_dbz;

  logic [DIV_LAT-1:0]    tag_v;
  logic [DIV_LAT-1:0]    tag_rem;
  logic [DIV_LAT-1:0]    tag_dbz;
  logic [ID_W-1:0]       tag_id [DIV_LAT];

  logic [N_REQ-1:0]        rsp_valid_q;
  logic [N_REQ*N_BITS-1:0] rsp_data_q;
  logic [N_BITS-1:0]       last_result;

  assign adv      = pea_ready_i && !mage_done_i;
  assign div_en_o = adv;

  // Search starts at ptr and wraps; the first valid requester wins.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    cand        = '0;
    if (adv) begin
      for (int k = 0; k < N_REQ; k++) begin
        sum = {1'b0, ptr} + (ID_W + 1)'(k);
        if (sum >= N_REQ_W) begin
          sum = sum - N_REQ_W;
        end
        cand = sum[ID_W-1:0];
        if (!grant_valid && pe.req_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    grant_vec   = '0;
    div_valid_o = 1'b0;
    div_a_o     = '0;
    div_b_o     = '0;
    grant_rem   = 1'b0;
    grant_dbz   = 1'b0;
    if (grant_valid) begin
      grant_vec[grant_idx] = 1'b1;
      div_valid_o          = 1'b1;
      div_a_o              = pe.req_a[int'(grant_idx)*N_BITS +: N_BITS];
      div_b_o              = pe.req_b[int'(grant_idx)*N_BITS +: N_BITS];
      grant_rem            = pe.req_rem[grant_idx];
      grant_dbz            = (div_b_o == '0);
    end
  end

  assign pe.req_ready = grant_vec;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr <= '0;
    end else if (mage_done_i) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == ID_MAX) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tags advance in lockstep with the divider, so they only move when it is enabled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tag_v   <= '0;
      tag_rem <= '0;
      tag_dbz <= '0;
      for (int i = 0; i < DIV_LAT; i++) begin
        tag_id[i] <= '0;
      end
    end else if (mage_done_i) begin
      tag_v <= '0;
    end else if (adv) begin
      tag_v[0]   <= grant_valid;
      tag_rem[0] <= grant_rem;
      tag_dbz[0] <= grant_dbz;
      tag_id[0]  <= grant_idx;
      for (int i = 1; i < DIV_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_rem[i] <= tag_rem[i-1];
        tag_dbz[i] <= tag_dbz[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Divide-by-zero quotients are forced to all-ones regardless of the divider's own output.
  assign last_result = tag_rem[LAST] ? div_r_i : (tag_dbz[LAST] ? '1 : div_q_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else if (mage_done_i) begin
      rsp_valid_q <= '0;
    end else if (adv) begin
      rsp_valid_q <= '0;
      if (tag_v[LAST]) begin
        rsp_valid_q[tag_id[LAST]] <= 1'b1;
        rsp_data_q[int'(tag_id[LAST])*N_BITS +: N_BITS] <= last_result;
      end
    end
  end

  assign pe.rsp_valid = rsp_valid_q;
  assign pe.rsp_data  = rsp_data_q;
  assign busy_o       = (|tag_v) || (|rsp_valid_q);

endmodule

// File: tb/tb_s_div_share_arbiter.sv
// Self-checking bench for s_div_share_arbiter: directed scenarios plus a randomized run
// compared against a queue-based reference model of arbitration and response timing.
module tb_s_div_share_arbiter;

  localparam int N_REQ   = 4;
  localparam int N_BITS  = 32;
  localparam int DIV_LAT = 4;

  typedef struct {
    int                id;
    logic [N_BITS-1:0] res;
    int                n;
  } entry_t;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              mage_done_i;
  logic              pea_ready_i;
  logic              div_en;
  logic              div_valid;
  logic [N_BITS-1:0] div_a;
  logic [N_BITS-1:0] div_b;
  logic [N_BITS-1:0] div_q;
  logic [N_BITS-1:0] div_r;
  logic              busy;

  int errors = 0;
  int checks = 0;

  s_div_share_arbiter_if #(.N_REQ(N_REQ), .N_BITS(N_BITS)) pe_bus ();

  s_div_share_arbiter #(.N_REQ(N_REQ), .N_BITS(N_BITS), .DIV_LAT(DIV_LAT)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .mage_done_i (mage_done_i),
    .pea_ready_i (pea_ready_i),
    .pe          (pe_bus),
    .div_en_o    (div_en),
    .div_valid_o (div_valid),
    .div_a_o     (div_a),
    .div_b_o     (div_b),
    .div_q_i     (div_q),
    .div_r_i     (div_r),
    .busy_o      (busy)
  );

  always #5 clk_i = ~clk_i;

  // Divider model: DIV_LAT-deep pipeline advancing only when div_en is high.
  logic [N_BITS-1:0] dm_a [DIV_LAT];
  logic [N_BITS-1:0] dm_b [DIV_LAT];

  always @(posedge clk_i) begin
    if (div_en) begin
      dm_a[0] <= div_a;
      dm_b[0] <= div_b;
      for (int i = 1; i < DIV_LAT; i++) begin
        dm_a[i] <= dm_a[i-1];
        dm_b[i] <= dm_b[i-1];
      end
    end
  end

  assign div_q = (dm_b[DIV_LAT-1] == '0) ? '1 : dm_a[DIV_LAT-1] / dm_b[DIV_LAT-1];
  assign div_r = (dm_b[DIV_LAT-1] == '0) ? dm_a[DIV_LAT-1] : dm_a[DIV_LAT-1] % dm_b[DIV_LAT-1];

  function automatic logic [N_BITS-1:0] ref_result(logic [N_BITS-1:0] a, logic [N_BITS-1:0] b,
                                                   logic rem);
    if (rem) return (b == '0) ? a : a % b;
    return (b == '0) ? '1 : a / b;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_inputs();
    pe_bus.req_valid = '0;
    pe_bus.req_a     = '0;
    pe_bus.req_b     = '0;
    pe_bus.req_rem   = '0;
    mage_done_i      = 1'b0;
    pea_ready_i      = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b,
                         input logic rem);
    pe_bus.req_valid[id]               = 1'b1;
    pe_bus.req_a[id*N_BITS +: N_BITS]  = a;
    pe_bus.req_b[id*N_BITS +: N_BITS]  = b;
    pe_bus.req_rem[id]                 = rem;
  endtask

  task automatic drop_req(input int id);
    pe_bus.req_valid[id] = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n_i = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (pe_bus.rsp_valid !== '0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", pe_bus.rsp_valid); end
    checks++; if (pe_bus.rsp_data !== '0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", pe_bus.rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pe_bus.req_ready !== '0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0", pe_bus.req_ready); end
    checks++; if (div_valid !== 1'b0 || div_a !== '0 || div_b !== '0) begin errors++; $display("[TB] FAIL reset_div_bus: got valid=%b a=%h b=%h expected 0", div_valid, div_a, div_b); end
    checks++; if (div_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_div_en: got %b expected 1", div_en); end
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_single_ops();
    int                id_t  [3] = '{0, 2, 1};
    logic [N_BITS-1:0] a_t   [3] = '{32'd100, 32'd100, 32'd50};
    logic [N_BITS-1:0] b_t   [3] = '{32'd7, 32'd7, 32'd0};
    logic              rem_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [N_BITS-1:0] exp_t [3] = '{32'd14, 32'd2, 32'hFFFF_FFFF};
    logic [N_REQ-1:0]  onehot;
    logic [N_REQ-1:0]  exp_v;
    for (int t = 0; t < 3; t++) begin
      clear_inputs();
      set_req(id_t[t], a_t[t], b_t[t], rem_t[t]);
      onehot = '0;
      onehot[id_t[t]] = 1'b1;
      #1;
      checks++; if (pe_bus.req_ready !== onehot) begin errors++; $display("[TB] FAIL single_grant[%0d]: got %b expected %b", t, pe_bus.req_ready, onehot); end
      checks++; if (div_valid !== 1'b1 || div_a !== a_t[t] || div_b !== b_t[t]) begin errors++; $display("[TB] FAIL single_issue[%0d]: got v=%b a=%0d b=%0d expected v=1 a=%0d b=%0d", t, div_valid, div_a, div_b, a_t[t], b_t[t]); end
      for (int c = 1; c <= 7; c++) begin
        tick();
        if (c == 1) drop_req(id_t[t]);
        #1;
        exp_v = (c == DIV_LAT + 1) ? onehot : '0;
        checks++; if (pe_bus.rsp_valid !== exp_v) begin errors++; $display("[TB] FAIL single_rsp_valid[%0d] c%0d: got %b expected %b", t, c, pe_bus.rsp_valid, exp_v); end
        if (c == DIV_LAT + 1) begin
          checks++; if (pe_bus.rsp_data[id_t[t]*N_BITS +: N_BITS] !== exp_t[t]) begin errors++; $display("[TB] FAIL single_rsp_data[%0d]: got %h expected %h", t, pe_bus.rsp_data[id_t[t]*N_BITS +: N_BITS], exp_t[t]); end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N_BITS-1:0] a_v [N_REQ];
    logic [N_BITS-1:0] b_v [N_REQ];
    logic [N_REQ-1:0]  exp_g;
    logic [N_REQ-1:0]  exp_v;
    int                rid;
    clear_inputs();
    mage_done_i = 1'b1;
    tick();
    mage_done_i = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      a_v[i] = 32'd1000 + 32'(37 * i);
      b_v[i] = 32'(i + 3);
      set_req(i, a_v[i], b_v[i], 1'b0);
    end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      #1;
      exp_g = N_REQ'(1) << (c % N_REQ);
      checks++; if (pe_bus.req_ready !== exp_g) begin errors++; $display("[TB] FAIL rr_grant c%0d: got %b expected %b", c, pe_bus.req_ready, exp_g); end
      if (c >= DIV_LAT + 1) begin
        rid   = (c - DIV_LAT - 1) % N_REQ;
        exp_v = N_REQ'(1) << rid;
        checks++; if (pe_bus.rsp_valid !== exp_v) begin errors++; $display("[TB] FAIL rr_rsp_valid c%0d: got %b expected %b", c, pe_bus.rsp_valid, exp_v); end
        checks++; if (pe_bus.rsp_data[rid*N_BITS +: N_BITS] !== a_v[rid] / b_v[rid]) begin errors++; $display("[TB] FAIL rr_rsp_data c%0d: got %0d expected %0d", c, pe_bus.rsp_data[rid*N_BITS +: N_BITS], a_v[rid] / b_v[rid]); end
      end else begin
        checks++; if (pe_bus.rsp_valid !== '0) begin errors++; $display("[TB] FAIL rr_rsp_early c%0d: got %b expected 0", c, pe_bus.rsp_valid); end
      end
    end
    clear_inputs();
    for (int c = 0; c < DIV_LAT + 3; c++) tick();
  endtask

  task automatic test_stall();
    logic exp_b;
    clear_inputs();
    for (int c = -3; c <= 10; c++) begin
      if (c > -3) tick();
      case (c)
        -3: set_req(0, 32'd81, 32'd9, 1'b0);
        -2: drop_req(0);
        0:  set_req(3, 32'd90, 32'd9, 1'b0);
        1:  drop_req(3);
        2:  begin pea_ready_i = 1'b0; set_req(1, 32'd77, 32'd7, 1'b0); end
        5:  pea_ready_i = 1'b1;
        6:  drop_req(1);
        default: ;
      endcase
      #1;
      if (c == -3) begin
        checks++; if (pe_bus.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL stall_grant_pe0: got %b expected 0001", pe_bus.req_ready); end
      end
      if (c == 0) begin
        checks++; if (pe_bus.req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL stall_grant_pe3: got %b expected 1000", pe_bus.req_ready); end
      end
      if (c >= 2 && c <= 4) begin
        checks++; if (pe_bus.req_ready !== '0 || div_en !== 1'b0 || div_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_idle c%0d: got rdy=%b en=%b v=%b expected 0", c, pe_bus.req_ready, div_en, div_valid); end
      end
      if (c == 5) begin
        checks++; if (pe_bus.req_ready !== 4'b0010 || div_en !== 1'b1) begin errors++; $display("[TB] FAIL stall_resume: got rdy=%b en=%b expected 0010/1", pe_bus.req_ready, div_en); end
      end
      if (c >= -2) begin
        exp_b = (c >= 2 && c <= 5);
        checks++; if (pe_bus.rsp_valid[0] !== exp_b) begin errors++; $display("[TB] FAIL stall_rsp_hold c%0d: got %b expected %b", c, pe_bus.rsp_valid[0], exp_b); end
      end
      if (c >= 1) begin
        exp_b = (c == 8);
        checks++; if (pe_bus.rsp_valid[3] !== exp_b) begin errors++; $display("[TB] FAIL stall_rsp_pe3 c%0d: got %b expected %b", c, pe_bus.rsp_valid[3], exp_b); end
        exp_b = (c == 10);
        checks++; if (pe_bus.rsp_valid[1] !== exp_b) begin errors++; $display("[TB] FAIL stall_rsp_pe1 c%0d: got %b expected %b", c, pe_bus.rsp_valid[1], exp_b); end
      end
      if (c == 8) begin
        checks++; if (pe_bus.rsp_data[3*N_BITS +: N_BITS] !== 32'd10) begin errors++; $display("[TB] FAIL stall_rsp_data: got %0d expected 10", pe_bus.rsp_data[3*N_BITS +: N_BITS]); end
      end
    end
    clear_inputs();
    for (int c = 0; c < DIV_LAT + 3; c++) tick();
  endtask

  task automatic test_flush(input logic use_reset);
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin tick(); drop_req(c - 1); end
      set_req(c, 32'd500 + 32'(c), 32'd3, 1'b0);
    end
    tick();
    drop_req(2);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy_before[%0d]: got %b expected 1", use_reset, busy); end
    if (use_reset) begin
      #2;
      rst_n_i = 1'b0;
      #1;
      checks++; if (pe_bus.rsp_valid !== '0 || pe_bus.rsp_data !== '0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_outputs: got v=%b d=%h busy=%b expected 0", pe_bus.rsp_valid, pe_bus.rsp_data, busy); end
      tick();
      rst_n_i = 1'b1;
    end else begin
      mage_done_i = 1'b1;
      set_req(3, 32'd9, 32'd3, 1'b0);
      #1;
      checks++; if (pe_bus.req_ready !== '0 || div_valid !== 1'b0 || div_en !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_grant: got rdy=%b v=%b en=%b expected 0", pe_bus.req_ready, div_valid, div_en); end
      tick();
      mage_done_i = 1'b0;
      drop_req(3);
    end
    for (int c = 0; c < 2 * DIV_LAT; c++) begin
      if (c > 0) tick();
      #1;
      checks++; if (pe_bus.rsp_valid !== '0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_quiet[%0d] c%0d: got v=%b busy=%b expected 0", use_reset, c, pe_bus.rsp_valid, busy); end
    end
    for (int i = 0; i < N_REQ; i++) set_req(i, 32'd1, 32'd1, 1'b0);
    #1;
    checks++; if (pe_bus.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL flush_ptr[%0d]: got %b expected 0001", use_reset, pe_bus.req_ready); end
    tick();
    clear_inputs();
    for (int c = 0; c < DIV_LAT + 3; c++) tick();
  endtask

  task automatic test_random();
    logic              pending [N_REQ];
    logic [N_BITS-1:0] op_a    [N_REQ];
    logic [N_BITS-1:0] op_b    [N_REQ];
    logic              op_rem  [N_REQ];
    logic [N_BITS-1:0] exp_data [N_REQ];
    logic [N_REQ-1:0]  exp_rsp_valid;
    logic [N_REQ-1:0]  exp_rdy;
    logic [N_BITS-1:0] ea;
    logic [N_BITS-1:0] eb;
    logic              exp_busy;
    entry_t            inflight [$];
    entry_t            e;
    int                mptr;
    int                adv_edges;
    int                g;
    int                idx;
    int                r;
    logic              pea;
    logic              md;
    logic              adv;

    clear_inputs();
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    mptr = 0;
    adv_edges = 0;
    exp_rsp_valid = '0;
    inflight.delete();
    for (int i = 0; i < N_REQ; i++) begin
      pending[i] = 1'b0;
      exp_data[i] = '0;
      op_a[i] = '0;
      op_b[i] = '0;
      op_rem[i] = 1'b0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1'b1;
          op_a[i] = $urandom;
          r = $urandom_range(0, 7);
          op_b[i] = (r == 0) ? '0 : ((r < 4) ? N_BITS'($urandom_range(1, 20)) : N_BITS'($urandom));
          op_rem[i] = 1'($urandom_range(0, 1));
        end
        pe_bus.req_valid[i] = pending[i];
        pe_bus.req_a[i*N_BITS +: N_BITS] = pending[i] ? op_a[i] : N_BITS'($urandom);
        pe_bus.req_b[i*N_BITS +: N_BITS] = pending[i] ? op_b[i] : N_BITS'($urandom);
        pe_bus.req_rem[i] = pending[i] ? op_rem[i] : 1'($urandom_range(0, 1));
      end
      pea = ($urandom_range(0, 4) != 0);
      md  = ($urandom_range(0, 39) == 0);
      pea_ready_i = pea;
      mage_done_i = md;
      #1;

      adv = pea && !md;
      g = -1;
      if (adv) begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = (mptr + k) % N_REQ;
          if (g < 0 && pending[idx]) g = idx;
        end
      end
      exp_rdy = '0;
      ea = '0;
      eb = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        ea = op_a[g];
        eb = op_b[g];
      end
      exp_busy = (inflight.size() != 0) || (exp_rsp_valid != '0);

      checks++; if (pe_bus.req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rnd_grant cyc%0d: got %b expected %b", cyc, pe_bus.req_ready, exp_rdy); end
      checks++; if (div_valid !== (g >= 0) || div_a !== ea || div_b !== eb) begin errors++; $display("[TB] FAIL rnd_issue cyc%0d: got v=%b a=%h b=%h expected v=%b a=%h b=%h", cyc, div_valid, div_a, div_b, (g >= 0), ea, eb); end
      checks++; if (div_en !== adv) begin errors++; $display("[TB] FAIL rnd_div_en cyc%0d: got %b expected %b", cyc, div_en, adv); end
      checks++; if (pe_bus.rsp_valid !== exp_rsp_valid) begin errors++; $display("[TB] FAIL rnd_rsp_valid cyc%0d: got %b expected %b", cyc, pe_bus.rsp_valid, exp_rsp_valid); end
      for (int i = 0; i < N_REQ; i++) begin
        checks++; if (pe_bus.rsp_data[i*N_BITS +: N_BITS] !== exp_data[i]) begin errors++; $display("[TB] FAIL rnd_rsp_data[%0d] cyc%0d: got %h expected %h", i, cyc, pe_bus.rsp_data[i*N_BITS +: N_BITS], exp_data[i]); end
      end
      checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL rnd_busy cyc%0d: got %b expected %b", cyc, busy, exp_busy); end

      // Model update for the coming edge: a response appears DIV_LAT advancing edges after its issue edge.
      if (md) begin
        inflight.delete();
        exp_rsp_valid = '0;
        mptr = 0;
      end else if (adv) begin
        adv_edges++;
        if (g >= 0) begin
          e.id  = g;
          e.res = ref_result(op_a[g], op_b[g], op_rem[g]);
          e.n   = adv_edges;
          inflight.push_back(e);
          pending[g] = 1'b0;
          mptr = (g + 1) % N_REQ;
        end
        exp_rsp_valid = '0;
        if (inflight.size() != 0 && inflight[0].n + DIV_LAT == adv_edges) begin
          e = inflight.pop_front();
          exp_rsp_valid[e.id] = 1'b1;
          exp_data[e.id] = e.res;
        end
      end
      tick();
    end
    clear_inputs();
    for (int c = 0; c < DIV_LAT + 3; c++) tick();
  endtask

  initial begin
    rst_n_i = 1'b0;
    clear_inputs();
    test_reset();
    test_single_ops();
    test_round_robin();
    test_stall();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
